// File: rtl/array_pkg.sv
// Shared types and constants for the array access sequencer.
package array_pkg;

  localparam int ARR_SIZE_DEFAULT = 1024;
  localparam int TIMEOUT_DEFAULT  = 16;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/array_bounds_check.sv
// Combinational bounds check and physical address formation for one array access.
module array_bounds_check
  import array_pkg::*;
#(
  parameter int  ARR_SIZE = ARR_SIZE_DEFAULT,
  localparam int ADDR     = $clog2(ARR_SIZE)
) (
  input  logic [31:0]     index_i,
  input  logic [ADDR:0]   length_i,
  input  logic [ADDR-1:0] base_i,
  output logic            oob_o,
  output logic [ADDR-1:0] addr_o
);

  logic [ADDR:0] sum;

  // One extra bit so a base+index past the end of memory is caught, not wrapped.
  assign sum    = {1'b0, base_i} + {1'b0, index_i[ADDR-1:0]};
  assign addr_o = sum[ADDR-1:0];
  assign oob_o  = index_i[31]
                | (index_i >= 32'(length_i))
                | (sum >= (ADDR+1)'(ARR_SIZE));

endmodule

// File: rtl/array_access_ctrl.sv
// iaload/iastore sequencer: bounds-check, drive the array block handshake, return data or error.
// Flow: IDLE -> CHECK -> ISSUE -> WAIT -> RESP -> IDLE, with CHECK -> RESP on out-of-bounds.
module array_access_ctrl
  import array_pkg::*;
#(
  parameter int  ARR_SIZE = ARR_SIZE_DEFAULT,
  parameter int  TIMEOUT  = TIMEOUT_DEFAULT,
  localparam int ADDR     = $clog2(ARR_SIZE)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            op_store_i,
  input  logic [ADDR-1:0] base_i,
  input  logic [ADDR:0]   length_i,
  input  logic [31:0]     index_i,
  input  logic [31:0]     store_value_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [31:0]     result_o,
  output logic            err_oob_o,
  output logic            err_timeout_o,
  output logic            arr_trigger_o,
  output logic            arr_write_o,
  output logic [ADDR-1:0] arr_addr_o,
  output logic [31:0]     arr_writevalue_o,
  input  logic [31:0]     arr_readvalue_i,
  input  logic            arr_done_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            op_store_q, op_store_d;
  logic [ADDR-1:0] base_q, base_d;
  logic [ADDR:0]   length_q, length_d;
  logic [31:0]     index_q, index_d;
  logic [31:0]     store_value_q, store_value_d;
  logic [ADDR-1:0] arr_addr_q, arr_addr_d;
  logic [31:0]     arr_wv_q, arr_wv_d;
  logic            arr_write_q, arr_write_d;
  logic [31:0]     result_q, result_d;
  logic            err_oob_q, err_oob_d;
  logic            err_to_q, err_to_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            oob;
  logic [ADDR-1:0] chk_addr;

  array_bounds_check #(.ARR_SIZE(ARR_SIZE)) u_bounds (
    .index_i  (index_q),
    .length_i (length_q),
    .base_i   (base_q),
    .oob_o    (oob),
    .addr_o   (chk_addr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      op_store_q    <= 1'b0;
      base_q        <= '0;
      length_q      <= '0;
      index_q       <= '0;
      store_value_q <= '0;
      arr_addr_q    <= '0;
      arr_wv_q      <= '0;
      arr_write_q   <= 1'b0;
      result_q      <= '0;
      err_oob_q     <= 1'b0;
      err_to_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      op_store_q    <= op_store_d;
      base_q        <= base_d;
      length_q      <= length_d;
      index_q       <= index_d;
      store_value_q <= store_value_d;
      arr_addr_q    <= arr_addr_d;
      arr_wv_q      <= arr_wv_d;
      arr_write_q   <= arr_write_d;
      result_q      <= result_d;
      err_oob_q     <= err_oob_d;
      err_to_q      <= err_to_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_store_d    = op_store_q;
    base_d        = base_q;
    length_d      = length_q;
    index_d       = index_q;
    store_value_d = store_value_q;
    arr_addr_d    = arr_addr_q;
    arr_wv_d      = arr_wv_q;
    arr_write_d   = arr_write_q;
    result_d      = result_q;
    err_oob_d     = err_oob_q;
    err_to_d      = err_to_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_store_d    = op_store_i;
          base_d        = base_i;
          length_d      = length_i;
          index_d       = index_i;
          store_value_d = store_value_i;
          err_oob_d     = 1'b0;
          err_to_d      = 1'b0;
          state_d       = CHECK;
        end
      end
      CHECK: begin
        if (oob) begin
          err_oob_d = 1'b1;
          state_d   = RESP;
        end else begin
          arr_addr_d  = chk_addr;
          arr_wv_d    = store_value_q;
          arr_write_d = (op_store_q == OP_STORE);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the last allowed cycle beats the timeout.
        if (arr_done_i) begin
          if (op_store_q == OP_LOAD) result_d = arr_readvalue_i;
          arr_write_d = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_to_d    = 1'b1;
          arr_write_d = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == RESP);
  assign err_oob_o        = done_o & err_oob_q;
  assign err_timeout_o    = done_o & err_to_q;
  assign result_o         = result_q;
  assign arr_trigger_o    = (state_q == ISSUE);
  assign arr_write_o      = arr_write_q;
  assign arr_addr_o       = arr_addr_q;
  assign arr_writevalue_o = arr_wv_q;

endmodule

// File: tb/tb_array_access_ctrl.sv
// Scoreboarded random/directed bench for array_access_ctrl with a behavioural array block.
module tb_array_access_ctrl;
  import array_pkg::*;

  localparam int ARR_SIZE = 1024;
  localparam int TIMEOUT  = 16;
  localparam int ADDR     = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i = 1'b0;
  logic            op_store_i = 1'b0;
  logic [ADDR-1:0] base_i = '0;
  logic [ADDR:0]   length_i = '0;
  logic [31:0]     index_i = '0;
  logic [31:0]     store_value_i = '0;
  logic            busy_o, done_o, err_oob_o, err_timeout_o;
  logic [31:0]     result_o;
  logic            arr_trigger_o, arr_write_o;
  logic [ADDR-1:0] arr_addr_o;
  logic [31:0]     arr_writevalue_o;
  logic [31:0]     arr_readvalue_i = '0;
  logic            arr_done_i = 1'b0;

  array_access_ctrl #(.ARR_SIZE(ARR_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start_i),
    .op_store_i       (op_store_i),
    .base_i           (base_i),
    .length_i         (length_i),
    .index_i          (index_i),
    .store_value_i    (store_value_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .result_o         (result_o),
    .err_oob_o        (err_oob_o),
    .err_timeout_o    (err_timeout_o),
    .arr_trigger_o    (arr_trigger_o),
    .arr_write_o      (arr_write_o),
    .arr_addr_o       (arr_addr_o),
    .arr_writevalue_o (arr_writevalue_o),
    .arr_readvalue_i  (arr_readvalue_i),
    .arr_done_i       (arr_done_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          oob;
    bit          to;
    bit          trig;
    logic [31:0] res;
    int          addr;
    bit          wr;
    int          lat;
    int          scyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ops = 0;
  int          dones = 0;
  int          trig_cnt = 0;
  int          trig_addr = 0;
  bit          trig_wr = 1'b0;
  int          model_lat = 0;
  bit          model_silent = 1'b0;
  logic [31:0] arr_mem [ARR_SIZE];
  logic [31:0] ref_mem [ARR_SIZE];
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural array block: answers each trigger after model_lat extra cycles unless silent.
  initial begin : array_model
    int          a;
    bit          w;
    logic [31:0] v;
    forever begin
      @(posedge clk);
      #1;
      arr_done_i = 1'b0;
      if (rst_n && arr_trigger_o && !model_silent) begin
        a = int'(arr_addr_o);
        w = arr_write_o;
        v = arr_writevalue_o;
        repeat (model_lat) @(posedge clk);
        @(posedge clk);
        #1;
        chk("arr_addr_stable", 32'(arr_addr_o), 32'(a));
        chk("arr_write_stable", 32'(arr_write_o), 32'(w));
        if (w) begin
          chk("arr_wv_stable", arr_writevalue_o, v);
          arr_mem[a] = v;
          arr_readvalue_i = $urandom;
        end else begin
          arr_readvalue_i = arr_mem[a];
        end
        arr_done_i = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (arr_trigger_o) begin
      trig_cnt++;
      trig_addr = int'(arr_addr_o);
      trig_wr   = arr_write_o;
    end
    if (done_o) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1, required no done (nothing pending)");
      end else begin
        mon_e = sb.pop_front();
        chk("err_oob", 32'(err_oob_o), 32'(mon_e.oob));
        chk("err_timeout", 32'(err_timeout_o), 32'(mon_e.to));
        chk("result", result_o, mon_e.res);
        chk("latency", 32'(cyc - mon_e.scyc), 32'(mon_e.lat));
        chk("trigger_count", 32'(trig_cnt), 32'(mon_e.trig));
        chk("busy_at_done", 32'(busy_o), 32'd1);
        if (mon_e.trig) begin
          chk("issued_addr", 32'(trig_addr), 32'(mon_e.addr));
          chk("issued_write", 32'(trig_wr), 32'(mon_e.wr));
        end
      end
      trig_cnt = 0;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy_o) return;
      @(negedge clk);
    end
    checks++;
    fails++;
    $display("FAIL wait_idle: got busy=1 after 300 cycles, required busy=0");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    fails++;
    $display("FAIL wait_done: got %0d pending after 300 cycles, required 0", sb.size());
    sb.delete();
  endtask

  task automatic do_op(input bit st, input int b, input int len, input logic [31:0] idx,
                       input logic [31:0] val, input int l, input bit sil, input bit extra);
    exp_t   e;
    longint ui;
    wait_idle();
    ui     = idx;
    e.oob  = idx[31] || (ui >= len) || (longint'(b) + ui >= ARR_SIZE);
    e.trig = !e.oob;
    e.to   = !e.oob && sil;
    e.addr = e.oob ? 0 : b + int'(ui);
    e.wr   = st;
    e.lat  = e.oob ? 2 : (sil ? TIMEOUT + 3 : 4 + l);
    if (!e.oob && !sil) begin
      if (st) ref_mem[e.addr] = val;
      else    last_res = ref_mem[e.addr];
    end
    e.res        = last_res;
    model_lat    = l;
    model_silent = sil;
    @(negedge clk);
    start_i       = 1'b1;
    op_store_i    = st;
    base_i        = ADDR'(b);
    length_i      = (ADDR+1)'(len);
    index_i       = idx;
    store_value_i = val;
    e.scyc        = cyc;
    sb.push_back(e);
    ops++;
    @(negedge clk);
    start_i       = 1'b0;
    op_store_i    = ~st;
    base_i        = ADDR'($urandom);
    index_i       = $urandom;
    store_value_i = $urandom;
    if (extra) begin
      @(negedge clk);
      start_i    = 1'b1;
      op_store_i = ~st;
      base_i     = '0;
      length_i   = 11'd8;
      index_i    = 32'd1;
      @(negedge clk);
      start_i    = 1'b0;
    end
    wait_drain();
  endtask

  initial begin : stimulus
    int          len, b, sel;
    logic [31:0] idx;
    int          d0;

    for (int i = 0; i < ARR_SIZE; i++) begin
      arr_mem[i] = $urandom;
      ref_mem[i] = arr_mem[i];
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_err_oob", 32'(err_oob_o), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout_o), 32'd0);
    chk("rst_trigger", 32'(arr_trigger_o), 32'd0);
    chk("rst_write", 32'(arr_write_o), 32'd0);
    chk("rst_addr", 32'(arr_addr_o), 32'd0);
    chk("rst_wv", arr_writevalue_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b1, 100, 8, 32'd5, 32'hDEADBEEF, 2, 1'b0, 1'b0);
    do_op(1'b0, 100, 8, 32'd5, 32'h0, 1, 1'b0, 1'b0);
    chk("load_deadbeef", result_o, 32'hDEADBEEF);
    do_op(1'b0, 100, 8, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, 1'b0);
    do_op(1'b0, 100, 8, 32'd8, 32'h0, 0, 1'b0, 1'b0);
    do_op(1'b0, 1016, 8, 32'd7, 32'h0, 0, 1'b0, 1'b0);
    do_op(1'b1, 1020, 8, 32'd4, 32'h1234_5678, 0, 1'b0, 1'b0);
    do_op(1'b0, 0, 0, 32'd0, 32'h0, 0, 1'b0, 1'b0);
    do_op(1'b0, 50, 8, 32'd2, 32'h0, 0, 1'b1, 1'b0);
    do_op(1'b0, 50, 8, 32'd2, 32'h0, TIMEOUT - 1, 1'b0, 1'b0);
    do_op(1'b1, 300, 16, 32'd3, 32'hCAFE_F00D, 3, 1'b0, 1'b1);
    do_op(1'b0, 300, 16, 32'd3, 32'h0, 0, 1'b0, 1'b1);

    // Abort a store stuck in WAIT with reset; nothing is pushed, so any done is flagged.
    wait_idle();
    model_silent = 1'b1;
    @(negedge clk);
    start_i       = 1'b1;
    op_store_i    = 1'b1;
    base_i        = 10'd200;
    length_i      = 11'd4;
    index_i       = 32'd1;
    store_value_i = 32'h5555_AAAA;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(busy_o), 32'd1);
    chk("pre_reset_write", 32'(arr_write_o), 32'd1);
    d0 = dones;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_write", 32'(arr_write_o), 32'd0);
    chk("abort_trigger", 32'(arr_trigger_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_addr", 32'(arr_addr_o), 32'd0);
    chk("abort_result", result_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    trig_cnt = 0;
    last_res = '0;
    model_silent = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_on_reset", 32'(dones), 32'(d0));
    do_op(1'b0, 200, 4, 32'd1, 32'h0, 1, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      len = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1024) : $urandom_range(0, 16);
      b   = $urandom_range(0, 1023);
      if ($urandom_range(0, 1) != 0 && len <= 1024) b = $urandom_range(0, 1024 - len);
      if (b > 1023) b = 1023;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       idx = 32'hFFFF_FFFF;
        1:       idx = 32'(len);
        2:       idx = $urandom;
        default: idx = (len > 0) ? 32'($urandom_range(0, len - 1)) : 32'd0;
      endcase
      do_op(1'($urandom_range(0, 1)), b, len, idx, $urandom, $urandom_range(0, TIMEOUT - 1),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("done_count", 32'(dones), 32'(ops));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
